// File: rtl/ram_pkg.sv
// Shared constants and state type for the dual-port RAM with clear sequencer.
package ram_pkg;

  localparam int WR_READ_FIRST  = 0;
  localparam int WR_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

endpackage

// File: rtl/ram_dp_core.sv
// Storage array with one byte-lane write/read port and one read-only port.
// Only the read registers are reset; the array itself stays reset-free.
module ram_dp_core
  import ram_pkg::*;
#(
  parameter int  DATA_W  = 16,
  parameter int  BYTE_W  = 8,
  parameter int  ADDR_W  = 10,
  parameter int  WR_MODE = WR_READ_FIRST,
  localparam int NB      = DATA_W / BYTE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_re,
  input  logic [NB-1:0]     a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_q,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_merged;

  // NOTE: the array has no reset so it maps onto block RAM; the clear sequencer initialises it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    a_merged = mem[a_addr];
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) a_merged[i*BYTE_W +: BYTE_W] = a_wdata[i*BYTE_W +: BYTE_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_re) a_q <= (WR_MODE == WR_WRITE_FIRST) ? a_merged : mem[a_addr];
      if (b_re) b_q <= mem[b_addr];
    end
  end

endmodule

// File: rtl/ram_dp.sv
// Dual-port RAM top: clear FSM muxed onto port A, read-valid and collision
// pipeline, optional output register stage.
module ram_dp
  import ram_pkg::*;
#(
  parameter int               DATA_W         = 16,
  parameter int               BYTE_W         = 8,
  parameter int               ADDR_W         = 10,
  parameter int               OUT_REG        = 0,
  parameter int               WR_MODE        = WR_READ_FIRST,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VAL      = '0,
  localparam int              NB             = DATA_W / BYTE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_en,
  input  logic [NB-1:0]     a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              ready,
  output logic              b_collide
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              a_acc, b_acc, hit;
  logic [NB-1:0]     core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, a_q, b_q;
  logic              a_v1, b_v1, col1;

  assign a_acc = a_en & ready;
  assign b_acc = b_en & ready;
  assign hit   = a_acc & b_acc & (|a_we) & (a_addr == b_addr);

  // While clearing, the sequencer owns port A and writes every lane.
  always_comb begin
    core_we    = '0;
    core_addr  = a_addr;
    core_wdata = a_wdata;
    if (state == CLEAR) begin
      core_we    = '1;
      core_addr  = clr_cnt;
      core_wdata = INIT_VAL;
    end else if (a_acc) begin
      core_we = a_we;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY:   ready <= 1'b1;
        default: state <= READY;
      endcase
    end
  end

  ram_dp_core #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .ADDR_W (ADDR_W),
    .WR_MODE(WR_MODE)
  ) u_core (
    .clock  (clock),
    .reset_n(reset_n),
    .a_re   (a_acc),
    .a_we   (core_we),
    .a_addr (core_addr),
    .a_wdata(core_wdata),
    .a_q    (a_q),
    .b_re   (b_acc),
    .b_addr (b_addr),
    .b_q    (b_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      col1 <= 1'b0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      col1 <= hit;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      // Data registers load only on a completing read so rdata holds otherwise.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_rdata   <= '0;
          b_rdata   <= '0;
          a_rvalid  <= 1'b0;
          b_rvalid  <= 1'b0;
          b_collide <= 1'b0;
        end else begin
          a_rvalid  <= a_v1;
          b_rvalid  <= b_v1;
          b_collide <= col1;
          if (a_v1) a_rdata <= a_q;
          if (b_v1) b_rdata <= b_q;
        end
      end
    end else begin : g_direct
      assign a_rdata   = a_q;
      assign b_rdata   = b_q;
      assign a_rvalid  = a_v1;
      assign b_rvalid  = b_v1;
      assign b_collide = col1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// Self-checking bench: three ram_dp configurations driven in parallel and
// compared each cycle against a word-array reference model.
module tb_ram_dp;

  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic [1:0]  a_we = '0;
  logic [9:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0;

  logic [15:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1, a_rdata2, b_rdata2;
  logic        a_rvalid0, b_rvalid0, ready0, b_collide0;
  logic        a_rvalid1, b_rvalid1, ready1, b_collide1;
  logic        a_rvalid2, b_rvalid2, ready2, b_collide2;

  int n_err = 0;
  int n_chk = 0;
  int m_edges = 0;

  logic [15:0] model [DEPTH];
  logic [15:0] exp0_ad, exp0_bd, exp1_ad, exp1_bd;
  logic        p_av, p_bv, p_col;
  logic [15:0] p_ad, p_bd;

  always #5 clock = ~clock;

  ram_dp #(.OUT_REG(0), .WR_MODE(0), .INIT_VAL(16'hA5A5)) dut0 (
    .clock(clock), .reset_n(reset_n), .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0), .b_en(b_en),
    .b_addr(b_addr), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0), .ready(ready0),
    .b_collide(b_collide0));

  ram_dp #(.OUT_REG(1), .WR_MODE(1), .INIT_VAL(16'hA5A5)) dut1 (
    .clock(clock), .reset_n(reset_n), .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1), .b_en(b_en),
    .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1), .ready(ready1),
    .b_collide(b_collide1));

  ram_dp #(.CLEAR_ON_RESET(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata2), .a_rvalid(a_rvalid2), .b_en(b_en),
    .b_addr(b_addr), .b_rdata(b_rdata2), .b_rvalid(b_rvalid2), .ready(ready2),
    .b_collide(b_collide2));

  task automatic idle();
    a_en = 1'b0; b_en = 1'b0; a_we = '0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    idle();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    m_edges = 0;
    exp0_ad = '0; exp0_bd = '0; exp1_ad = '0; exp1_bd = '0;
    p_av = 1'b0; p_bv = 1'b0; p_col = 1'b0; p_ad = '0; p_bd = '0;
  endtask

  // One clock edge with the current inputs; the model decides acceptance from
  // the edge count since reset release and predicts every output.
  task automatic step();
    logic        acc_a, acc_b, col;
    logic [15:0] old_a, new_a, old_b;
    acc_a = a_en && (m_edges >= DEPTH);
    acc_b = b_en && (m_edges >= DEPTH);
    old_a = model[a_addr];
    old_b = model[b_addr];
    new_a = old_a;
    if (a_we[0]) new_a[7:0]  = a_wdata[7:0];
    if (a_we[1]) new_a[15:8] = a_wdata[15:8];
    col = acc_a && acc_b && (a_we != 2'b00) && (a_addr == b_addr);
    if (acc_a) model[a_addr] = new_a;
    @(posedge clock); #1;
    if (m_edges <= DEPTH) m_edges++;
    if (m_edges == DEPTH) for (int i = 0; i < DEPTH; i++) model[i] = 16'hA5A5;
    if (acc_a) exp0_ad = old_a;
    if (acc_b) exp0_bd = old_b;
    if (p_av) exp1_ad = p_ad;
    if (p_bv) exp1_bd = p_bd;

    n_chk++; if (ready0 !== (m_edges >= DEPTH)) begin n_err++; $display("FAIL dut0 ready @%0d: got %b expected %b", m_edges, ready0, m_edges >= DEPTH); end
    n_chk++; if (ready1 !== (m_edges >= DEPTH)) begin n_err++; $display("FAIL dut1 ready @%0d: got %b expected %b", m_edges, ready1, m_edges >= DEPTH); end
    n_chk++; if (ready2 !== (m_edges >= 1)) begin n_err++; $display("FAIL dut2 ready @%0d: got %b expected %b", m_edges, ready2, m_edges >= 1); end
    n_chk++; if (a_rvalid0 !== acc_a) begin n_err++; $display("FAIL dut0 a_rvalid: got %b expected %b", a_rvalid0, acc_a); end
    n_chk++; if (a_rdata0 !== exp0_ad) begin n_err++; $display("FAIL dut0 a_rdata: got %h expected %h", a_rdata0, exp0_ad); end
    n_chk++; if (b_rvalid0 !== acc_b) begin n_err++; $display("FAIL dut0 b_rvalid: got %b expected %b", b_rvalid0, acc_b); end
    n_chk++; if (b_rdata0 !== exp0_bd) begin n_err++; $display("FAIL dut0 b_rdata: got %h expected %h", b_rdata0, exp0_bd); end
    n_chk++; if (b_collide0 !== col) begin n_err++; $display("FAIL dut0 b_collide: got %b expected %b", b_collide0, col); end
    n_chk++; if (a_rvalid1 !== p_av) begin n_err++; $display("FAIL dut1 a_rvalid: got %b expected %b", a_rvalid1, p_av); end
    n_chk++; if (a_rdata1 !== exp1_ad) begin n_err++; $display("FAIL dut1 a_rdata: got %h expected %h", a_rdata1, exp1_ad); end
    n_chk++; if (b_rvalid1 !== p_bv) begin n_err++; $display("FAIL dut1 b_rvalid: got %b expected %b", b_rvalid1, p_bv); end
    n_chk++; if (b_rdata1 !== exp1_bd) begin n_err++; $display("FAIL dut1 b_rdata: got %h expected %h", b_rdata1, exp1_bd); end
    n_chk++; if (b_collide1 !== p_col) begin n_err++; $display("FAIL dut1 b_collide: got %b expected %b", b_collide1, p_col); end

    p_av = acc_a; p_ad = new_a; p_bv = acc_b; p_bd = old_b; p_col = col;
  endtask

  task automatic write_a(input logic [9:0] addr, input logic [15:0] data, input logic [1:0] we);
    a_en = 1'b1; a_we = we; a_addr = addr; a_wdata = data; b_en = 1'b0;
    step();
    idle();
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if ({a_rdata0, b_rdata0, a_rvalid0, b_rvalid0, ready0, b_collide0} !== 36'h0) begin n_err++; $display("FAIL reset dut0 outputs: got %h expected 0", {a_rdata0, b_rdata0, a_rvalid0, b_rvalid0, ready0, b_collide0}); end
    n_chk++; if ({a_rdata1, b_rdata1, a_rvalid1, b_rvalid1, ready1, b_collide1} !== 36'h0) begin n_err++; $display("FAIL reset dut1 outputs: got %h expected 0", {a_rdata1, b_rdata1, a_rvalid1, b_rvalid1, ready1, b_collide1}); end
    n_chk++; if (ready2 !== 1'b0) begin n_err++; $display("FAIL reset dut2 ready: got %b expected 0", ready2); end
    do_reset();
  endtask

  task automatic test_clear();
    logic [9:0] addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
    while (m_edges < DEPTH) step();
    n_chk++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL clear ready after %0d edges: got %b expected 1", m_edges, ready0); end
    for (int k = 0; k < 3; k++) begin
      b_en = 1'b1; b_addr = addrs[k];
      step();
      n_chk++; if (b_rvalid0 !== 1'b1 || b_rdata0 !== 16'hA5A5) begin n_err++; $display("FAIL clear read %0d: got v=%b %h expected v=1 a5a5", addrs[k], b_rvalid0, b_rdata0); end
    end
    idle();
    step();
  endtask

  task automatic test_byte_lanes();
    write_a(10'd5, 16'h1234, 2'b11);
    write_a(10'd5, 16'hAB00, 2'b10);
    a_en = 1'b1; a_we = 2'b00; a_addr = 10'd5;
    step();
    idle();
    n_chk++; if (a_rdata0 !== 16'hAB34) begin n_err++; $display("FAIL byte lanes: got %h expected ab34", a_rdata0); end
    step();
  endtask

  task automatic test_rw_mode();
    write_a(10'd7, 16'h1111, 2'b11);
    write_a(10'd7, 16'h2222, 2'b11);
    n_chk++; if (a_rdata0 !== 16'h1111) begin n_err++; $display("FAIL read-first: got %h expected 1111", a_rdata0); end
    step();
    n_chk++; if (a_rdata1 !== 16'h2222) begin n_err++; $display("FAIL write-first: got %h expected 2222", a_rdata1); end
  endtask

  task automatic test_collision();
    write_a(10'd9, 16'h0001, 2'b11);
    a_en = 1'b1; a_we = 2'b11; a_addr = 10'd9; a_wdata = 16'h0002; b_en = 1'b1; b_addr = 10'd9;
    step();
    n_chk++; if (b_rdata0 !== 16'h0001 || b_collide0 !== 1'b1) begin n_err++; $display("FAIL collide: got %h c=%b expected 0001 c=1", b_rdata0, b_collide0); end
    a_en = 1'b0; a_we = 2'b00;
    step();
    n_chk++; if (b_rdata0 !== 16'h0002 || b_collide0 !== 1'b0) begin n_err++; $display("FAIL after collide: got %h c=%b expected 0002 c=0", b_rdata0, b_collide0); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) write_a(10'(k), 16'hC000 + 16'(k), 2'b11);
    for (int k = 0; k < 6; k++) begin
      b_en = (k < 4); b_addr = 10'(k);
      step();
      if (k >= 1 && k <= 4) begin
        n_chk++; if (b_rvalid1 !== 1'b1 || b_rdata1 !== 16'hC000 + 16'(k - 1)) begin n_err++; $display("FAIL out_reg b2b %0d: got v=%b %h expected v=1 %h", k - 1, b_rvalid1, b_rdata1, 16'hC000 + 16'(k - 1)); end
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a_en = 1'($urandom_range(0, 1)); a_we = 2'($urandom); a_addr = 10'($urandom_range(0, 15));
      a_wdata = 16'($urandom); b_en = 1'($urandom_range(0, 1)); b_addr = 10'($urandom_range(0, 15));
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    while (m_edges < 300) step();
    #1 reset_n = 1'b0;
    #1;
    n_chk++; if ({a_rdata1, b_rdata1, a_rvalid1, ready0, ready1} !== 35'h0) begin n_err++; $display("FAIL mid-clear reset outputs: got %h expected 0", {a_rdata1, b_rdata1, a_rvalid1, ready0, ready1}); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_edges = 0;
    while (m_edges < DEPTH) begin
      if (m_edges == 500) begin
        a_en = 1'b1; a_we = 2'b11; a_addr = 10'd3; a_wdata = 16'h1234; b_en = 1'b1; b_addr = 10'd3;
      end else idle();
      step();
    end
    idle();
    b_en = 1'b1; b_addr = 10'd3;
    step();
    n_chk++; if (b_rdata0 !== 16'hA5A5) begin n_err++; $display("FAIL write during clear: got %h expected a5a5", b_rdata0); end
    idle();
    step();
    step();
  endtask

  initial begin
    exp0_ad = '0; exp0_bd = '0; exp1_ad = '0; exp1_bd = '0;
    p_av = 1'b0; p_bv = 1'b0; p_col = 1'b0; p_ad = '0; p_bd = '0;
    test_reset();
    test_clear();
    test_byte_lanes();
    test_rw_mode();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
# ram_dp

Parametrised simple dual-port block RAM with one clock: port A read/write with byte-lane write enables, port B read-only. Adds a hardware clear sequencer that fills the array with a constant after reset, an optional output register stage, selectable port-A read-during-write mode, explicit read-valid strobes, and an A-write/B-read collision flag. Used wherever the design needs buffer or scratch memory that must start in a known state without relying on a hex image.

## Interface
- DATA_W, 16, word width; must be a multiple of BYTE_W
- BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2
- WR_MODE, 0, port-A read-during-write: 0 read-first (old data), 1 write-first (new data)
- CLEAR_ON_RESET, 1, 1 = run clear sequencer after reset; 0 = ready immediately
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer

- clock  in  1  sole clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- a_en  in  1  port-A access request
- a_we  in  NB  per-lane write enable; 0 = pure read
- a_addr  in  ADDR_W  port-A word address
- a_wdata  in  DATA_W  port-A write data
- a_rdata  out  DATA_W  port-A read data
- a_rvalid  out  1  a_rdata valid this cycle
- b_en  in  1  port-B read request
- b_addr  in  ADDR_W  port-B word address
- b_rdata  out  DATA_W  port-B read data
- b_rvalid  out  1  b_rdata valid this cycle
- ready  out  1  clear done; requests are accepted only while high
- b_collide  out  1  b_rdata was read from an address port A wrote the same cycle

## Operation
- Reset (reset_n low): a_rdata, b_rdata = 0; a_rvalid, b_rvalid, ready, b_collide = 0; FSM to CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0); clear counter = 0. Array contents are not reset.
- FSM states: CLEAR, READY. CLEAR: each edge writes INIT_VAL (all lanes) to address = counter, counter+1; after writing DEPTH-1, go to READY. READY is terminal until the next reset.
- Reset mid-clear restarts at address 0.
- While ready=0, a_en and b_en are ignored: no writes, and rvalid stays 0.
- Accepted request: en high on an edge where ready was high before that edge.
- Port A write: lane i of mem[a_addr] takes a_wdata lane i where a_we[i]=1; other lanes unchanged. A read is also issued; a_rdata returns old word (WR_MODE=0) or merged new word (WR_MODE=1).
- Port B: reads mem[b_addr]. If A writes the same address in the same cycle (any a_we bit set), b_rdata returns the old word and b_collide asserts aligned with b_rvalid.
- rdata holds its last value when no read completes; rvalid and b_collide are single-cycle strobes.

## Timing
- Latency L = 1 + OUT_REG edges from acceptance to rvalid/rdata; full throughput, one access per port per cycle, no back-pressure.
- Clear takes DEPTH edges after reset release; ready rises after edge DEPTH. A request on edge DEPTH+1 is accepted.
- CLEAR_ON_RESET=0: ready high after the first edge following reset release.
- b_collide is pipelined with b_rvalid; both delayed equally by OUT_REG.

## Structure
- Package ram_pkg: WR_READ_FIRST/WR_WRITE_FIRST constants and the CLEAR/READY state enum.
- Sub-module ram_dp_core: reset-free storage array with one write/read port and one read port, lane enables and WR_MODE, kept separate so block RAM infers cleanly. Top level holds the FSM, clear mux onto port A, valid/collision pipeline and OUT_REG stage.

## Test plan
- Clear: default params, INIT_VAL=16'hA5A5; release reset, count edges -> ready rises after edge 1024; B reads of 0, 511 and 1023 return A5A5 with b_rvalid one cycle later.
- Byte lanes: write 16'h1234 to 5 with a_we=2'b11, then 16'hAB00 with a_we=2'b10 -> read of 5 returns 16'hAB34.
- RW mode: mem[7]=16'h1111; write 16'h2222 to 7 with a_en -> a_rdata 16'h1111 (WR_MODE=0) or 16'h2222 (WR_MODE=1).
- Collision: mem[9]=16'h0001; same cycle A writes 16'h0002 to 9 and B reads 9 -> b_rdata 16'h0001, b_collide=1; next B read of 9 -> 16'h0002, b_collide=0.
- OUT_REG=1: back-to-back B reads of addresses 0..3 -> b_rvalid two edges after each request; data stays in order with no gaps.
- Reset mid-clear: pull reset_n low at edge 300, release -> ready stays 0 and rises 1024 edges after release; requests during clear produce no rvalid and no writes.
